// File: rtl/md_unit_pkg.sv
// Shared md-unit definitions: op codes driven by the E-stage decoder and default latencies.
// The divide helper keeps signed-division corner cases in one place.
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MADD  = 3'd5;
    localparam logic [2:0] MD_MTHI  = 3'd6;
    localparam logic [2:0] MD_MTLO  = 3'd7;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Returns {remainder, quotient}. The signed path divides magnitudes, so
    // 0x80000000 / -1 wraps to 0x80000000 with no overflow special case.
    function automatic logic [63:0] md_div(input logic [31:0] num,
                                           input logic [31:0] den,
                                           input logic        sgn);
        logic        neg_n;
        logic        neg_d;
        logic [31:0] mag_n;
        logic [31:0] mag_d;
        logic [31:0] quo;
        logic [31:0] rem;
        neg_n = sgn & num[31];
        neg_d = sgn & den[31];
        mag_n = neg_n ? (32'd0 - num) : num;
        mag_d = neg_d ? (32'd0 - den) : den;
        if (mag_d == 32'd0) begin
            quo = 32'd0;
            rem = 32'd0;
        end else begin
            quo = mag_n / mag_d;
            rem = mag_n % mag_d;
        end
        if (neg_n ^ neg_d) quo = 32'd0 - quo;
        if (neg_n)         rem = 32'd0 - rem;
        return {rem, quo};
    endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO. The result is computed at accept and
// held pending; a down-counter models the latency and commits on its final tick.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [63:0]   r_pend;
    logic          r_wr;

    logic [63:0]   w_sa;
    logic [63:0]   w_sb;
    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic [63:0]   w_madd;
    logic [63:0]   w_div_s;
    logic [63:0]   w_div_u;
    logic          w_ld;
    logic          w_wr;
    logic [CW-1:0] w_cnt_ld;
    logic [63:0]   w_res;

    // Sign-extended 64-bit operands make a mod-2^64 product equal to the signed product.
    assign w_sa     = {{32{a[31]}}, a};
    assign w_sb     = {{32{b[31]}}, b};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = {32'd0, a} * {32'd0, b};
    assign w_madd   = {r_hi, r_lo} + w_prod_s;
    assign w_div_s  = md_div(a, b, 1'b1);
    assign w_div_u  = md_div(a, b, 1'b0);

    always_comb begin
        w_ld     = 1'b0;
        w_wr     = 1'b0;
        w_cnt_ld = '0;
        w_res    = '0;
        case (md_op)
            MD_MULT: begin
                w_ld = 1'b1; w_wr = 1'b1; w_cnt_ld = MULT_LD; w_res = w_prod_s;
            end
            MD_MULTU: begin
                w_ld = 1'b1; w_wr = 1'b1; w_cnt_ld = MULT_LD; w_res = w_prod_u;
            end
            MD_MADD: begin
                w_ld = 1'b1; w_wr = 1'b1; w_cnt_ld = MULT_LD; w_res = w_madd;
            end
            // A zero divisor still costs the full latency but never writes HI/LO.
            MD_DIV: begin
                w_ld = 1'b1; w_wr = (b != 32'd0); w_cnt_ld = DIV_LD; w_res = w_div_s;
            end
            MD_DIVU: begin
                w_ld = 1'b1; w_wr = (b != 32'd0); w_cnt_ld = DIV_LD; w_res = w_div_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_pend <= '0;
            r_wr   <= 1'b0;
        end else if (r_cnt != '0) begin
            // Any start seen here is dropped, including on the commit edge.
            r_cnt  <= r_cnt - CNT_ONE;
            r_busy <= (r_cnt != CNT_ONE);
            if (r_cnt == CNT_ONE && r_wr) begin
                r_hi <= r_pend[63:32];
                r_lo <= r_pend[31:0];
            end
        end else if (start) begin
            if (w_ld) begin
                r_cnt  <= w_cnt_ld;
                r_busy <= 1'b1;
                r_pend <= w_res;
                r_wr   <= w_wr;
            end else if (md_op == MD_MTHI) begin
                r_hi <= a;
            end else if (md_op == MD_MTLO) begin
                r_lo <= a;
            end
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues per-cycle expected busy/hi/lo,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_md_unit;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = MD_NONE;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        eb;
        logic [31:0] eh;
        logic [31:0] el;
        string       nm;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    task automatic chk(input string nm, input logic eb, input logic [31:0] eh, input logic [31:0] el);
        checks++;
        if (busy !== eb || hi !== eh || lo !== el) begin
            failures++;
            $display("FAIL %s @cyc%0d: got busy=%0b hi=%h lo=%h, expected busy=%0b hi=%h lo=%h",
                     nm, cyc, busy, hi, lo, eb, eh, el);
        end
    endtask

    function automatic void push(input int c, input logic eb, input logic [31:0] eh,
                                 input logic [31:0] el, input string nm);
        exp_t e;
        e.c = c; e.eb = eb; e.eh = eh; e.el = el; e.nm = nm;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            if (e.c < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation for cyc%0d missed at cyc%0d", e.nm, e.c, cyc);
            end else begin
                chk(e.nm, e.eb, e.eh, e.el);
            end
        end
    end

    // Called on a negedge; the op is sampled at the next posedge.
    task automatic do_mt(input logic [2:0] op, input logic [31:0] av,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
        start = 1'b1; md_op = op; a = av; b = '0;
        push(cyc + 1, 1'b0, eh, el, nm);
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        cur_hi = eh; cur_lo = el;
    endtask

    task automatic do_md(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input int n, input logic [31:0] eh, input logic [31:0] el, input string nm);
        int t;
        t = cyc + 1;
        start = 1'b1; md_op = op; a = av; b = bv;
        for (int k = 0; k < n; k++) push(t + k, 1'b1, cur_hi, cur_lo, {nm, "_busy"});
        push(t + n, 1'b0, eh, el, nm);
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE; a = '1; b = '1;
        repeat (n) @(negedge clk);
        cur_hi = eh; cur_lo = el;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        push(cyc + 1, 1'b0, 32'h0, 32'h0, "reset_state");
        @(negedge clk);
        reset = 1'b1;

        do_mt(MD_MTHI, 32'h11, 32'h11, 32'h0, "mthi_pre");
        do_mt(MD_MTLO, 32'h22, 32'h11, 32'h22, "mtlo_pre");

        // Reset in the middle of a mult: pending result must vanish.
        t = cyc + 1;
        start = 1'b1; md_op = MD_MULT; a = 32'd3; b = 32'd4;
        push(t, 1'b1, 32'h11, 32'h22, "rst_mid_busy0");
        push(t + 1, 1'b1, 32'h11, 32'h22, "rst_mid_busy1");
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("reset_async", 1'b0, 32'h0, 32'h0);
        push(t + 2, 1'b0, 32'h0, 32'h0, "reset_hold");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 3; k <= 8; k++) push(t + k, 1'b0, 32'h0, 32'h0, "reset_after");
        repeat (6) @(negedge clk);
        cur_hi = '0; cur_lo = '0;

        do_md(MD_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");
        do_md(MD_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, "multu");
        do_md(MD_MADD,  32'd1,        32'd2,        5,  32'h00000002, 32'h00000000, "madd_pos");
        do_md(MD_MADD,  32'hFFFFFFFF, 32'd3,        5,  32'h00000001, 32'hFFFFFFFD, "madd_neg");
        do_md(MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_negnum");
        do_md(MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negden");
        do_md(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf");
        do_md(MD_DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E, "divu");
        do_md(MD_DIVU,  32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC, "divu_big");

        do_mt(MD_MTHI, 32'h1234, 32'h1234, cur_lo,   "mthi");
        do_mt(MD_MTLO, 32'h5678, 32'h1234, 32'h5678, "mtlo");
        do_mt(MD_NONE, 32'hBEEF, 32'h1234, 32'h5678, "op_none");
        do_md(MD_DIVU, 32'd9, 32'd0, 10, 32'h1234, 32'h5678, "divu_zero");

        // Starts while busy (including on the commit edge) are dropped.
        t = cyc + 1;
        start = 1'b1; md_op = MD_MULT; a = 32'd2; b = 32'd2;
        for (int k = 0; k < 5; k++) push(t + k, 1'b1, cur_hi, cur_lo, "ign_busy");
        push(t + 5, 1'b0, 32'h0, 32'h4, "ign_commit");
        push(t + 6, 1'b0, 32'h0, 32'h4, "ign_after");
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        repeat (2) @(negedge clk);
        start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        @(negedge clk);
        start = 1'b1; md_op = MD_MTHI; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        repeat (3) @(negedge clk);

        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
